// File: rtl/pll_mon_pkg.sv
// Shared types and default constants for the PLL lock monitor (12 MHz ref -> 60 MHz clock).
package pll_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        EVAL
    } mon_state_e;

    localparam int unsigned DEF_EXPECTED_COUNT   = 5000;
    localparam int unsigned DEF_WINDOW_REF_EDGES = 1000;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous input plus a delay flop for rising-edge detection.
module sync_edge_detect (
    input  logic clock,
    input  logic reset_n,
    input  logic async_in,
    output logic rise_pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic dly_q, dly_d;

    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        dly_d   = sync2_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            dly_q   <= dly_d;
        end
    end

    assign rise_pulse = sync2_q & ~dly_q;

endmodule

// File: rtl/pll_lock_monitor.sv
// Frequency-lock monitor and display-domain reset generator for the PLL output clock.
// Define PLL_MON_RESET_GEN_EN to hold sys_reset_n low for RESET_HOLD cycles after lock.
module pll_lock_monitor
    import pll_mon_pkg::*;
#(
    parameter int unsigned WINDOW_REF_EDGES = DEF_WINDOW_REF_EDGES,
    parameter int unsigned EXPECTED_COUNT   = DEF_EXPECTED_COUNT,
    parameter int unsigned TOLERANCE        = 8,
    parameter int unsigned LOCK_WINDOWS     = 4,
    parameter int unsigned REF_TIMEOUT      = 64,
    parameter int unsigned RESET_HOLD       = 256,
    parameter int unsigned CNT_W            = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ref_clock_in,
    output logic             locked,
    output logic             ref_lost,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_valid,
    output logic             sys_reset_n
);

    localparam int unsigned EDGE_W = $clog2(WINDOW_REF_EDGES + 1);
    localparam int unsigned GOOD_W = $clog2(LOCK_WINDOWS + 1);
    localparam int unsigned TO_W   = $clog2(REF_TIMEOUT + 1);
    localparam logic signed [CNT_W:0] EXP_S = (CNT_W+1)'(EXPECTED_COUNT);
    localparam logic signed [CNT_W:0] TOL_S = (CNT_W+1)'(TOLERANCE);

    logic ref_edge;

    sync_edge_detect u_sync (
        .clock      (clock),
        .reset_n    (reset_n),
        .async_in   (ref_clock_in),
        .rise_pulse (ref_edge)
    );

    mon_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d, cyc_inc;
    logic [CNT_W-1:0]  meas_count_q, meas_count_d;
    logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              locked_q, locked_d;
    logic              ref_lost_q, ref_lost_d;
    logic              meas_valid_q, meas_valid_d;
    logic              sys_reset_n_q, sys_reset_n_d;
    logic signed [CNT_W:0] diff;
    logic              window_good;

    always_comb begin
        cyc_inc     = (cyc_q == '1) ? cyc_q : cyc_q + 1'b1;
        diff        = $signed({1'b0, meas_count_q}) - EXP_S;
        window_good = (meas_count_q != '1) && (diff <= TOL_S) && (diff >= -TOL_S);
    end

    // The ending edge of one window is the starting edge of the next, so the
    // cycle counter keeps running through EVAL without a gap.
    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        edge_cnt_d   = edge_cnt_q;
        good_d       = good_q;
        to_d         = to_q;
        locked_d     = locked_q;
        ref_lost_d   = ref_lost_q;
        meas_count_d = meas_count_q;
        meas_valid_d = 1'b0;

        if (ref_edge) begin
            ref_lost_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                to_d = '0;
                if (ref_edge) begin
                    cyc_d      = '0;
                    edge_cnt_d = '0;
                    state_d    = MEASURE;
                end
            end
            MEASURE, EVAL: begin
                if (state_q == EVAL) begin
                    state_d = MEASURE;
                    if (window_good) begin
                        if (good_q != GOOD_W'(LOCK_WINDOWS)) begin
                            good_d = good_q + 1'b1;
                        end
                    end else begin
                        good_d = '0;
                    end
                    locked_d = (good_d == GOOD_W'(LOCK_WINDOWS));
                end
                cyc_d = cyc_inc;
                if (ref_edge) begin
                    to_d = '0;
                    if (edge_cnt_q == EDGE_W'(WINDOW_REF_EDGES - 1)) begin
                        meas_count_d = cyc_inc;
                        meas_valid_d = 1'b1;
                        cyc_d        = '0;
                        edge_cnt_d   = '0;
                        state_d      = EVAL;
                    end else begin
                        edge_cnt_d = edge_cnt_q + 1'b1;
                    end
                end else if (to_q == TO_W'(REF_TIMEOUT - 1)) begin
                    ref_lost_d = 1'b1;
                    locked_d   = 1'b0;
                    good_d     = '0;
                    to_d       = '0;
                    state_d    = IDLE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef PLL_MON_RESET_GEN_EN
    localparam int unsigned HOLD_W = $clog2(RESET_HOLD + 1);

    logic [HOLD_W-1:0] hold_q, hold_d;

    // Driven from locked_d so the display reset falls in the same cycle as locked.
    always_comb begin
        hold_d = hold_q;
        if (!locked_q) begin
            hold_d = '0;
        end else if (hold_q != HOLD_W'(RESET_HOLD)) begin
            hold_d = hold_q + 1'b1;
        end
        sys_reset_n_d = locked_d && (hold_d == HOLD_W'(RESET_HOLD));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    always_comb begin
        sys_reset_n_d = locked_q;
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cyc_q         <= '0;
            edge_cnt_q    <= '0;
            good_q        <= '0;
            to_q          <= '0;
            locked_q      <= 1'b0;
            ref_lost_q    <= 1'b0;
            meas_count_q  <= '0;
            meas_valid_q  <= 1'b0;
            sys_reset_n_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cyc_q         <= cyc_d;
            edge_cnt_q    <= edge_cnt_d;
            good_q        <= good_d;
            to_q          <= to_d;
            locked_q      <= locked_d;
            ref_lost_q    <= ref_lost_d;
            meas_count_q  <= meas_count_d;
            meas_valid_q  <= meas_valid_d;
            sys_reset_n_q <= sys_reset_n_d;
        end
    end

    assign locked      = locked_q;
    assign ref_lost    = ref_lost_q;
    assign meas_count  = meas_count_q;
    assign meas_valid  = meas_valid_q;
    assign sys_reset_n = sys_reset_n_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Self-checking bench for pll_lock_monitor: event-level reference model of windows, lock and timeout.
module tb_pll_lock_monitor;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ref_clock_in = 1'b0;
    logic        locked, ref_lost, meas_valid, sys_reset_n;
    logic [15:0] meas_count;

    always #5 clock = ~clock;

    pll_lock_monitor #(
        .WINDOW_REF_EDGES (10),
        .EXPECTED_COUNT   (50),
        .TOLERANCE        (2),
        .LOCK_WINDOWS     (2),
        .REF_TIMEOUT      (64),
        .RESET_HOLD       (16),
        .CNT_W            (16)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .ref_clock_in (ref_clock_in),
        .locked       (locked),
        .ref_lost     (ref_lost),
        .meas_count   (meas_count),
        .meas_valid   (meas_valid),
        .sys_reset_n  (sys_reset_n)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit prev_lvl = 1'b0;
    bit lv[$];
    int edge_q[$];

    // Reference model: window = 10 reference periods, DUT sees a driven edge 2 cycles later.
    bit          measuring;
    int          win_start, last_edge, n_edges, good_run, rise_cyc;
    bit          r_v[8];
    logic [15:0] r_cnt[8];
    int          r_lock[8];
    int          r_lost[8];
    bit          e_valid, e_locked, e_lost, e_sys, e_locked_prev;
    logic [15:0] e_count;
    logic [19:0] got, want;

    function automatic void push_period(int p, int hi);
        for (int i = 0; i < p; i++) lv.push_back(i < hi);
    endfunction

    function automatic void push_low(int n);
        for (int i = 0; i < n; i++) lv.push_back(1'b0);
    endfunction

    function automatic void model_reset();
        measuring = 0; n_edges = 0; good_run = 0; win_start = 0; last_edge = 0; rise_cyc = 0;
        e_valid = 0; e_locked = 0; e_lost = 0; e_sys = 0; e_locked_prev = 0; e_count = '0;
        edge_q.delete();
        for (int i = 0; i < 8; i++) begin
            r_v[i] = 0; r_cnt[i] = '0; r_lock[i] = -1; r_lost[i] = -1;
        end
    endfunction

    function automatic void model_cycle();
        int  s, n1, n2, d;
        bit  edge_now;
        s  = cyc % 8;
        n1 = (cyc + 1) % 8;
        n2 = (cyc + 2) % 8;
        e_valid = r_v[s];
        if (r_v[s]) e_count = r_cnt[s];
        r_v[s] = 0;
        if (r_lock[s] >= 0) e_locked = (r_lock[s] != 0);
        if (r_lost[s] >= 0) e_lost = (r_lost[s] != 0);
        r_lock[s] = -1; r_lost[s] = -1;
`ifdef PLL_MON_RESET_GEN_EN
        if (e_locked && !e_locked_prev) rise_cyc = cyc;
        e_sys = e_locked && (cyc - rise_cyc >= 16);
`else
        e_sys = e_locked_prev;
`endif
        e_locked_prev = e_locked;

        edge_now = (edge_q.size() > 0) && (edge_q[0] == cyc);
        if (edge_now) begin
            void'(edge_q.pop_front());
            r_lost[n1] = 0;
            if (!measuring) begin
                measuring = 1; win_start = cyc; n_edges = 0;
            end else begin
                n_edges++;
                if (n_edges == 10) begin
                    r_v[n1] = 1;
                    r_cnt[n1] = 16'(cyc - win_start);
                    d = cyc - win_start - 50;
                    good_run = (d >= -2 && d <= 2) ? ((good_run < 2) ? good_run + 1 : 2) : 0;
                    r_lock[n2] = (good_run == 2) ? 1 : 0;
                    win_start = cyc; n_edges = 0;
                end
            end
            last_edge = cyc;
        end else if (measuring && (cyc - last_edge == 64)) begin
            measuring = 0; good_run = 0;
            r_lost[n1] = 1; r_lock[n1] = 0;
        end
    endfunction

    task automatic step();
        bit lvl;
        lvl = (lv.size() > 0) ? lv.pop_front() : 1'b0;
        @(posedge clock);
        cyc++;
        #1 ref_clock_in = lvl;
        if (reset_n) begin
            if (lvl && !prev_lvl) edge_q.push_back(cyc + 2);
            model_cycle();
        end else begin
            model_reset();
        end
        prev_lvl = lvl;
        @(negedge clock);
        got  = {meas_valid, meas_count, locked, ref_lost, sys_reset_n};
        want = {e_valid, e_count, e_locked, e_lost, e_sys};
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        got = {meas_valid, meas_count, locked, ref_lost, sys_reset_n};
        vectors++;
        if (got !== 20'h0) begin
            miscompares++;
            $display("FAIL reset_values got=%h exp=%h", got, 20'h0);
        end
        reset_n = 1'b1;
        repeat (4) begin
            step();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL post_reset cyc=%0d got=%h exp=%h", cyc, got, want);
            end
        end
    endtask

    task automatic test_exact_period();
        push_low(int'($urandom_range(1, 4)));
        for (int i = 0; i < 51; i++) push_period(5, int'($urandom_range(1, 4)));
        while (lv.size() > 0) begin
            step();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL exact_period cyc=%0d got=%h exp=%h", cyc, got, want);
            end
        end
    endtask

    task automatic test_single_bad();
        for (int i = 0; i < 8; i++) push_period(5, int'($urandom_range(1, 4)));
        push_period(8, int'($urandom_range(1, 7)));
        for (int i = 0; i < 21; i++) push_period(5, int'($urandom_range(1, 4)));
        while (lv.size() > 0) begin
            step();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL single_bad cyc=%0d got=%h exp=%h", cyc, got, want);
            end
        end
    endtask

    task automatic test_ref_stop();
        push_low(90);
        for (int i = 0; i < 25; i++) push_period(5, int'($urandom_range(1, 4)));
        while (lv.size() > 0) begin
            step();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL ref_stop cyc=%0d got=%h exp=%h", cyc, got, want);
            end
        end
    endtask

    task automatic test_reset_mid_window();
        for (int i = 0; i < 15; i++) push_period(5, int'($urandom_range(1, 4)));
        push_period(3, 1);
        while (lv.size() > 0) begin
            step();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL pre_abort cyc=%0d got=%h exp=%h", cyc, got, want);
            end
        end
        #2 reset_n = 1'b0;
        #1 got = {meas_valid, meas_count, locked, ref_lost, sys_reset_n};
        model_reset();
        vectors++;
        if (got !== 20'h0) begin
            miscompares++;
            $display("FAIL async_abort got=%h exp=%h", got, 20'h0);
        end
        push_low(3);
        while (lv.size() > 0) begin
            step();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL in_reset cyc=%0d got=%h exp=%h", cyc, got, want);
            end
        end
        reset_n = 1'b1;
    endtask

    task automatic test_off_frequency();
        push_low(2);
        for (int i = 0; i < 31; i++) push_period((i % 2 == 0) ? 5 : 6, 2);
        while (lv.size() > 0) begin
            step();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL off_frequency cyc=%0d got=%h exp=%h", cyc, got, want);
            end
        end
    endtask

    task automatic test_random_windows();
        int idx, d, p;
        for (int w = 0; w < 8; w++) begin
            idx = int'($urandom_range(0, 9));
            d   = int'($urandom_range(0, 6)) - 3;
            for (int k = 0; k < 10; k++) begin
                p = (k == idx) ? 5 + d : 5;
                push_period(p, int'($urandom_range(1, p - 1)));
            end
        end
        push_period(5, 2);
        push_low(8);
        while (lv.size() > 0) begin
            step();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL random_windows cyc=%0d got=%h exp=%h", cyc, got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_exact_period();
        test_single_bad();
        test_ref_stop();
        test_reset_mid_window();
        test_off_frequency();
        test_random_windows();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
